// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if
//   Bundles the CPU word handshake and the line-wide memory bus of the
//   set-associative data cache.
//   slave  : the cache side (takes CPU requests, issues memory requests)
//   master : the environment side (CPU stage plus backing DataMemory)
//   CPU:    is_input_valid, mem_rw, addr, din -> is_ready, is_hit,
//           is_output_valid, dout
//   Memory: mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din ->
//           mem_ready, mem_is_output_valid, mem_dout
interface set_assoc_cache_if #(
    parameter int LINE_SIZE = 16
);
    logic                     is_input_valid;
    logic                     mem_rw;
    logic [31:0]              addr;
    logic [31:0]              din;
    logic                     is_ready;
    logic                     is_hit;
    logic                     is_output_valid;
    logic [31:0]              dout;

    logic                     mem_is_input_valid;
    logic                     mem_read;
    logic                     mem_write;
    logic [31:0]              mem_addr;
    logic [LINE_SIZE*8-1:0]   mem_din;
    logic                     mem_ready;
    logic                     mem_is_output_valid;
    logic [LINE_SIZE*8-1:0]   mem_dout;

    modport slave (
        input  is_input_valid, mem_rw, addr, din,
        input  mem_ready, mem_is_output_valid, mem_dout,
        output is_ready, is_hit, is_output_valid, dout,
        output mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din
    );

    modport master (
        output is_input_valid, mem_rw, addr, din,
        output mem_ready, mem_is_output_valid, mem_dout,
        input  is_ready, is_hit, is_output_valid, dout,
        input  mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din
    );
endinterface

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//   N-way set-associative, write-back, write-allocate data cache with
//   true-LRU replacement. Blocking: one miss at a time.
//   Ports:
//     clk      : clock, all state changes on posedge
//     reset_n  : synchronous active-low reset
//     bus      : set_assoc_cache_if.slave (CPU handshake + memory bus)
//     hit_count, miss_count : 32-bit saturating statistics, present only
//                             when CACHE_STATS_EN is defined
//   Optional feature macro: CACHE_STATS_EN
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   IDLE      | serving hits, detecting misses (is_ready = 1)
//   WRITEBACK | writing the dirty victim line to memory
//   FILL_REQ  | requesting the missed line from memory
//   FILL_WAIT | waiting for the returned line, then installing it
module set_assoc_cache #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 8,
    parameter int NUM_WAYS  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    set_assoc_cache_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int OFFSET = $clog2(LINE_SIZE);
    localparam int INDEX  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - INDEX - OFFSET;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W = LINE_SIZE * 8;
    localparam int WSEL_W = OFFSET - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL_REQ, FILL_WAIT} state_t;

    state_t             state_q;
    logic               is_ready_q;
    logic               mem_valid_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [31:0]        mem_addr_q;
    logic [LINE_W-1:0]  mem_din_q;
    logic [WAY_W-1:0]   victim_q;
    logic [INDEX-1:0]   miss_idx_q;
    logic [TAG_W-1:0]   miss_tag_q;

    logic               valid_q [NUM_SETS][NUM_WAYS];
    logic               dirty_q [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]  data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]   age_q   [NUM_SETS][NUM_WAYS];

    logic [INDEX-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  req_word;
    logic               addr_unused;

    assign req_idx     = bus.addr[OFFSET+INDEX-1:OFFSET];
    assign req_tag     = bus.addr[31:OFFSET+INDEX];
    assign req_word    = bus.addr[OFFSET-1:2];
    assign addr_unused = ^bus.addr[1:0];

    logic               hit;
    logic [WAY_W-1:0]   hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; with a full set the oldest way goes.
    logic               found_inv;
    logic [WAY_W-1:0]   victim_way;

    always_comb begin
        found_inv  = 1'b0;
        victim_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                found_inv  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    // One LRU touch per cycle at most: an IDLE hit or a fill install.
    logic               lru_en;
    logic [INDEX-1:0]   lru_set;
    logic [WAY_W-1:0]   lru_way;

    always_comb begin
        lru_en  = 1'b0;
        lru_set = req_idx;
        lru_way = hit_way;
        if (state_q == IDLE && bus.is_input_valid && hit) begin
            lru_en = 1'b1;
        end else if (state_q == FILL_WAIT && bus.mem_is_output_valid) begin
            lru_en  = 1'b1;
            lru_set = miss_idx_q;
            lru_way = victim_q;
        end
    end

    assign bus.is_ready           = is_ready_q;
    assign bus.is_hit             = hit;
    assign bus.is_output_valid    = is_ready_q && bus.is_input_valid && hit;
    assign bus.dout               = data_q[req_idx][hit_way][{req_word, 5'd0} +: 32];
    assign bus.mem_is_input_valid = mem_valid_q;
    assign bus.mem_read           = mem_read_q;
    assign bus.mem_write          = mem_write_q;
    assign bus.mem_addr           = mem_addr_q;
    assign bus.mem_din            = mem_din_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            is_ready_q  <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (lru_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == lru_way) begin
                        age_q[lru_set][w] <= '0;
                    end else if (age_q[lru_set][w] < age_q[lru_set][lru_way]) begin
                        age_q[lru_set][w] <= age_q[lru_set][w] + 1'b1;
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.is_input_valid) begin
                        if (hit) begin
                            if (bus.mem_rw) begin
                                data_q[req_idx][hit_way][{req_word, 5'd0} +: 32] <= bus.din;
                                dirty_q[req_idx][hit_way] <= 1'b1;
                            end
                        end else begin
                            victim_q    <= victim_way;
                            miss_idx_q  <= req_idx;
                            miss_tag_q  <= req_tag;
                            is_ready_q  <= 1'b0;
                            mem_valid_q <= 1'b1;
                            if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
                                state_q     <= WRITEBACK;
                                mem_write_q <= 1'b1;
                                mem_addr_q  <= {tag_q[req_idx][victim_way], req_idx, {OFFSET{1'b0}}};
                                mem_din_q   <= data_q[req_idx][victim_way];
                            end else begin
                                state_q    <= FILL_REQ;
                                mem_read_q <= 1'b1;
                                mem_addr_q <= {req_tag, req_idx, {OFFSET{1'b0}}};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state_q     <= FILL_REQ;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {miss_tag_q, miss_idx_q, {OFFSET{1'b0}}};
                    end
                end
                FILL_REQ: begin
                    if (bus.mem_ready) begin
                        state_q     <= FILL_WAIT;
                        mem_valid_q <= 1'b0;
                        mem_read_q  <= 1'b0;
                    end
                end
                FILL_WAIT: begin
                    if (bus.mem_is_output_valid) begin
                        state_q                        <= IDLE;
                        is_ready_q                     <= 1'b1;
                        valid_q[miss_idx_q][victim_q]  <= 1'b1;
                        dirty_q[miss_idx_q][victim_q]  <= 1'b0;
                        tag_q[miss_idx_q][victim_q]    <= miss_tag_q;
                        data_q[miss_idx_q][victim_q]   <= bus.mem_dout;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // post_fill_q marks that the next IDLE hit is the replay of a missed
    // request and must not be counted as a hit.
    logic post_fill_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            post_fill_q <= 1'b0;
        end else if (state_q == FILL_WAIT && bus.mem_is_output_valid) begin
            post_fill_q <= 1'b1;
        end else if (state_q == IDLE && bus.is_input_valid) begin
            if (hit) begin
                if (!post_fill_q && hit_count != '1) begin
                    hit_count <= hit_count + 1'b1;
                end
                post_fill_q <= 1'b0;
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement. It replaces the direct-mapped data cache between the CPU memory stage and the line-wide data memory. The CPU side keeps the existing word handshake (`is_ready`, `is_hit`, `is_output_valid`). The memory side is exposed as ports so the backing DataMemory is instantiated one level up.

## Interface
- `LINE_SIZE`, 16: line size in bytes; power of two, ≥ 8.
- `NUM_SETS`, 8: number of sets; power of two, ≥ 2.
- `NUM_WAYS`, 2: ways per set; power of two, ≥ 1. A value of 1 gives a direct-mapped cache.

- `clk` input 1: clock; all state changes on posedge.
- `reset_n` input 1: reset; synchronous, active-low.
- `is_input_valid` input 1: CPU request present.
- `mem_rw` input 1: 1 = write, 0 = read.
- `addr` input 32: byte address; bits [1:0] are ignored.
- `din` input 32: write word.
- `is_ready` output 1: cache is in IDLE.
- `is_hit` output 1: tag match on a valid way of the indexed set (combinational).
- `is_output_valid` output 1: `is_input_valid && is_hit` while in IDLE.
- `dout` output 32: addressed word of the hit way (combinational).
- `mem_is_input_valid` output 1: memory request valid.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `mem_addr` output 32: line-aligned memory address.
- `mem_din` output LINE_SIZE*8: victim line for writeback.
- `mem_ready` input 1: memory accepts a request this cycle.
- `mem_is_output_valid` input 1: read line returned.
- `mem_dout` input LINE_SIZE*8: returned line.

## Operation
- Address split:
  - OFFSET = log2(LINE_SIZE) bits.
  - INDEX = log2(NUM_SETS) bits, at `addr[OFFSET+INDEX-1:OFFSET]`.
  - TAG = 32 − INDEX − OFFSET bits.
  - Word select = `addr[OFFSET-1:2]`.
- Per way, per set: valid, dirty, tag, line data, and an LRU age of log2(NUM_WAYS) bits (0 = MRU).
- States:
  - IDLE:
    - Hit read: `dout` is valid the same cycle.
    - Hit write: the word is written at the posedge and dirty is set.
    - Miss: go to WRITEBACK if the victim is valid and dirty, else FILL_REQ.
  - WRITEBACK:
    - Drive `mem_is_input_valid`=1, `mem_write`=1, `mem_addr`={victim tag, index, OFFSET'b0}, `mem_din`=victim line.
    - On `mem_ready` go to FILL_REQ.
  - FILL_REQ:
    - Drive `mem_is_input_valid`=1, `mem_read`=1, `mem_addr`={addr[31:OFFSET], OFFSET'b0}.
    - On `mem_ready` go to FILL_WAIT.
  - FILL_WAIT:
    - All memory request outputs are 0.
    - On `mem_is_output_valid`: install `mem_dout` into the victim way with valid=1, dirty=0, tag; make that way MRU; go to IDLE.
- Write misses always allocate. After the fill, the request hits in IDLE and the write is performed then.
- Victim selection:
  - The lowest-index invalid way.
  - If every way is valid, the way whose age is NUM_WAYS−1.
  - The victim is latched on leaving IDLE.
- LRU update happens on every IDLE hit (with `is_input_valid`) and on every fill:
  - The accessed way's age becomes 0.
  - Ways with age below its old age increment.
  - Ages in a set always form a permutation of 0..NUM_WAYS−1.
- The requester holds `addr`, `mem_rw` and `din` stable from the miss until `is_output_valid`. Changing them in between is a protocol violation with undefined result.
- A miss never overlaps another miss; the cache is blocking.

## Timing
- Hit latency is 0 cycles (combinational `dout`/`is_output_valid`). The write commits at the same posedge.
- Clean miss: IDLE → FILL_REQ → FILL_WAIT → IDLE. `is_ready`=0 from the cycle after the miss until the fill posedge. The hit is seen in the first IDLE cycle after the fill.
- Dirty miss adds WRITEBACK: at least 1 cycle, plus the wait for `mem_ready`.
- `mem_is_input_valid`, `mem_read` and `mem_write` decode purely from state and hold until accepted.
- Reset values when `reset_n`=0 at a posedge:
  - State = IDLE.
  - All valid and dirty bits = 0.
  - Way w age = w.
  - `is_ready`=1, `is_output_valid`=0, `mem_is_input_valid`=`mem_read`=`mem_write`=0.
- Reset mid-miss, in any state: the transaction is abandoned, no line is installed, and the memory request outputs are 0 on the cycle after the reset edge.
- `mem_is_output_valid` outside FILL_WAIT is ignored.

## Configuration
- `CACHE_STATS_EN` defined: two extra output ports are compiled in, each 32 bits, saturating, and cleared by reset.
  - `hit_count` increments once per completed request whose first IDLE evaluation was a hit.
  - `miss_count` increments once per IDLE→miss transition.
  - The post-fill hit of a missed request is not counted as a hit.
- `CACHE_STATS_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
The bench uses NUM_SETS=4, NUM_WAYS=2, LINE_SIZE=16, so 0x000, 0x040 and 0x080 all map to set 0.
- Cold read: read 0x004 after reset → `is_hit`=0. One FILL_REQ with `mem_addr`=0x000. The memory returns line 0x44443333_22221111_00000000_AAAAAAAA. Then `is_output_valid`=1 with `dout`=0x00000000, `is_ready`=1.
- LRU: fill 0x000 then 0x040, read 0x000, read 0x080 → the fill evicts 0x040's way. A follow-up read of 0x000 hits with no memory activity.
- Write-allocate: write 0x0C8 with 0xDEADBEEF to a cold cache → read fill of 0x0C0, then the write hits. Reading 0x0C8 returns 0xDEADBEEF; the other words match memory.
- Dirty eviction: dirty 0x000 and 0x040, then read 0x080 → WRITEBACK of the LRU line with correct `mem_addr` and `mem_din` containing the written word, then the fill of 0x080. Holding `mem_ready`=0 for 5 cycles keeps `mem_write`=1 throughout.
- Reset mid-FILL_WAIT: assert `reset_n`=0 → `is_ready`=1 and all memory request outputs are 0 on the next cycle. Re-reading 0x000 misses again.
- With `CACHE_STATS_EN`: 3 misses then 2 hits → `miss_count`=3, `hit_count`=2.
